// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// Imported by the sequencer, its interface users and the bench.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MULTI = 2'd1,
        S_JPEND = 2'd2
    } state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int MAX_STALL_DEF = 64;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the pipeline stages and the sequencer.
// slave = sequencer side, master = the stages driving requests.
interface pipe_ctrl_if;

    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        ex_hold_i;
    logic        mdu_done_i;
    logic        bus_stall_i;

    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        pc_hold_o;
    logic        if_id_hold_o;
    logic        id_ex_hold_o;
    logic        if_id_flush_o;
    logic        id_ex_flush_o;

    modport slave (
        input  jump_en_i, jump_addr_i, ex_hold_i,
        input  mdu_done_i, bus_stall_i,
        output jump_en_o, jump_addr_o, pc_hold_o,
        output if_id_hold_o, id_ex_hold_o,
        output if_id_flush_o, id_ex_flush_o
    );

    modport master (
        output jump_en_i, jump_addr_i, ex_hold_i,
        output mdu_done_i, bus_stall_i,
        input  jump_en_o, jump_addr_o, pc_hold_o,
        input  if_id_hold_o, id_ex_hold_o,
        input  if_id_flush_o, id_ex_flush_o
    );

endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: redirect, hold and flush control
// for PC, IF/ID and ID/EX, plus MDU wait timeout and flush counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_STALL = MAX_STALL_DEF,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_ctrl_if.slave       ctl,
    output logic             timeout_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [1:0]       state_o
);

    localparam int SW = (MAX_STALL > 1) ? $clog2(MAX_STALL) : 1;
    localparam logic [SW-1:0] LAST = SW'(MAX_STALL - 1);

    state_e           state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [31:0]      jaddr_q, jaddr_d;
    logic [CNT_W-1:0] fcnt_q;
    logic             tout_q, tout_d;
    logic             fc_inc;

    logic        jen;
    logic [31:0] jaddr;
    logic        pc_h, ifid_h, idex_h;
    logic        ifid_f, idex_f;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        jaddr_d = jaddr_q;
        tout_d  = 1'b0;
        fc_inc  = 1'b0;
        jen     = 1'b0;
        jaddr   = 32'h0;
        pc_h    = 1'b0;
        ifid_h  = 1'b0;
        idex_h  = 1'b0;
        ifid_f  = 1'b0;
        idex_f  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ctl.jump_en_i) begin
                    ifid_f = 1'b1;
                    idex_f = 1'b1;
                    fc_inc = 1'b1;
                    if (!ctl.bus_stall_i) begin
                        jen   = 1'b1;
                        jaddr = ctl.jump_addr_i;
                    end else begin
                        // fetch busy: park the target until the bus frees up
                        jaddr_d = ctl.jump_addr_i;
                        pc_h    = 1'b1;
                        state_d = S_JPEND;
                    end
                end else if (ctl.ex_hold_i) begin
                    pc_h    = 1'b1;
                    ifid_h  = 1'b1;
                    idex_h  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_MULTI;
                end else if (ctl.bus_stall_i) begin
                    pc_h   = 1'b1;
                    ifid_f = 1'b1;
                end
            end
            S_MULTI: begin
                cnt_d = cnt_q + SW'(1);
                if (ctl.mdu_done_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    tout_d  = 1'b1;
                end else begin
                    pc_h   = 1'b1;
                    ifid_h = 1'b1;
                    idex_h = 1'b1;
                end
            end
            S_JPEND: begin
                ifid_f = 1'b1;
                idex_f = 1'b1;
                if (ctl.bus_stall_i) begin
                    pc_h = 1'b1;
                end else begin
                    jen     = 1'b1;
                    jaddr   = jaddr_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (!rst_n) begin
            jen    = 1'b0;
            jaddr  = 32'h0;
            pc_h   = 1'b0;
            ifid_h = 1'b0;
            idex_h = 1'b0;
            ifid_f = 1'b0;
            idex_f = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            jaddr_q <= 32'h0;
            fcnt_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            jaddr_q <= jaddr_d;
            tout_q  <= tout_d;
            if (fc_inc) begin
                fcnt_q <= fcnt_q + CNT_W'(1);
            end
        end
    end

    assign ctl.jump_en_o     = jen;
    assign ctl.jump_addr_o   = jaddr;
    assign ctl.pc_hold_o     = pc_h;
    assign ctl.if_id_hold_o  = ifid_h;
    assign ctl.id_ex_hold_o  = idex_h;
    assign ctl.if_id_flush_o = ifid_f;
    assign ctl.id_ex_flush_o = idex_f;

    assign timeout_o   = tout_q;
    assign flush_cnt_o = fcnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for the pipeline sequencer.
// Mealy bundle order: {jen, pc_h, ifid_h, idex_h, ifid_f, idex_f, addr}.
module tb_pipe_ctrl;

    logic       clk;
    logic       rst_n;
    logic       timeout;
    logic [3:0] fcnt;
    logic [1:0] state;
    int         errors;
    int         checks;

    pipe_ctrl_if ctl ();

    pipe_ctrl #(
        .MAX_STALL(64),
        .CNT_W    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctl        (ctl.slave),
        .timeout_o  (timeout),
        .flush_cnt_o(fcnt),
        .state_o    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [37:0] mealy = {ctl.jump_en_o, ctl.pc_hold_o,
                         ctl.if_id_hold_o, ctl.id_ex_hold_o,
                         ctl.if_id_flush_o, ctl.id_ex_flush_o,
                         ctl.jump_addr_o};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        ctl.jump_en_i   = 1'b0;
        ctl.jump_addr_i = 32'h0;
        ctl.ex_hold_i   = 1'b0;
        ctl.mdu_done_i  = 1'b0;
        ctl.bus_stall_i = 1'b0;
    endtask

    task automatic do_reset();
        clr_in();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ctl.jump_en_i   = 1'b1;
        ctl.jump_addr_i = 32'h55;
        ctl.bus_stall_i = 1'b1;
        tick();
        checks++;
        if (mealy !== 38'h0) begin
            errors++;
            $display("FAIL rst_mealy got=%h exp=0", mealy);
        end
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL rst_state got=%0d exp=0", state);
        end
        checks++;
        if (timeout !== 1'b0 || fcnt !== 4'd0) begin
            errors++;
            $display("FAIL rst_regs got=%b/%0d exp=0/0", timeout, fcnt);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (mealy !== {6'b010011, 32'h0}) begin
            errors++;
            $display("FAIL rst_release got=%h exp=%h",
                     mealy, {6'b010011, 32'h0});
        end
        clr_in();
        tick();
        checks++;
        if (state !== 2'd0 || fcnt !== 4'd0) begin
            errors++;
            $display("FAIL rst_idle got=%0d/%0d exp=0/0", state, fcnt);
        end
    endtask

    task automatic test_jump();
        do_reset();
        ctl.jump_en_i   = 1'b1;
        ctl.jump_addr_i = 32'h100;
        #1;
        checks++;
        if (mealy !== {6'b100011, 32'h100}) begin
            errors++;
            $display("FAIL jump_mealy got=%h exp=%h",
                     mealy, {6'b100011, 32'h100});
        end
        tick();
        clr_in();
        #1;
        checks++;
        if (fcnt !== 4'd1 || state !== 2'd0 || mealy !== 38'h0) begin
            errors++;
            $display("FAIL jump_after got=%0d/%0d/%h exp=1/0/0",
                     fcnt, state, mealy);
        end
    endtask

    task automatic test_jump_stall();
        do_reset();
        ctl.jump_en_i   = 1'b1;
        ctl.jump_addr_i = 32'h200;
        ctl.bus_stall_i = 1'b1;
        #1;
        checks++;
        if (mealy !== {6'b010011, 32'h0}) begin
            errors++;
            $display("FAIL jst_entry got=%h exp=%h",
                     mealy, {6'b010011, 32'h0});
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            ctl.jump_en_i   = (i == 1);
            ctl.jump_addr_i = 32'h300;
            #1;
            checks++;
            if (state !== 2'd2 || mealy !== {6'b010011, 32'h0}) begin
                errors++;
                $display("FAIL jst_wait%0d got=%0d/%h exp=2/%h",
                         i, state, mealy, {6'b010011, 32'h0});
            end
        end
        tick();
        ctl.bus_stall_i = 1'b0;
        #1;
        checks++;
        if (mealy !== {6'b100011, 32'h200}) begin
            errors++;
            $display("FAIL jst_fire got=%h exp=%h",
                     mealy, {6'b100011, 32'h200});
        end
        tick();
        clr_in();
        #1;
        checks++;
        if (state !== 2'd0 || fcnt !== 4'd1 || mealy !== 38'h0) begin
            errors++;
            $display("FAIL jst_done got=%0d/%0d/%h exp=0/1/0",
                     state, fcnt, mealy);
        end
    endtask

    task automatic test_mdu();
        do_reset();
        ctl.ex_hold_i = 1'b1;
        #1;
        checks++;
        if (mealy !== {6'b011100, 32'h0}) begin
            errors++;
            $display("FAIL mdu_entry got=%h exp=%h",
                     mealy, {6'b011100, 32'h0});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            ctl.ex_hold_i = 1'b0;
            #1;
            checks++;
            if (state !== 2'd1 || mealy !== {6'b011100, 32'h0}) begin
                errors++;
                $display("FAIL mdu_hold%0d got=%0d/%h exp=1/%h",
                         i, state, mealy, {6'b011100, 32'h0});
            end
        end
        tick();
        ctl.mdu_done_i = 1'b1;
        #1;
        checks++;
        if (mealy !== 38'h0) begin
            errors++;
            $display("FAIL mdu_done got=%h exp=0", mealy);
        end
        tick();
        clr_in();
        #1;
        checks++;
        if (state !== 2'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL mdu_exit got=%0d/%b exp=0/0", state, timeout);
        end
    endtask

    task automatic run_wait(input bit done_last);
        int hc;
        do_reset();
        ctl.ex_hold_i = 1'b1;
        #1;
        hc = (ctl.pc_hold_o & ctl.if_id_hold_o & ctl.id_ex_hold_o) ? 1 : 0;
        for (int i = 0; i < 63; i++) begin
            tick();
            ctl.ex_hold_i = 1'b0;
            #1;
            if (state == 2'd1 && ctl.pc_hold_o && ctl.if_id_hold_o &&
                ctl.id_ex_hold_o)
                hc++;
        end
        tick();
        ctl.mdu_done_i = done_last;
        #1;
        checks++;
        if (hc != 64 || mealy !== 38'h0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_holds d=%b got=%0d/%h/%b exp=64/0/0",
                     done_last, hc, mealy, timeout);
        end
        tick();
        clr_in();
        #1;
        checks++;
        if (state !== 2'd0 || timeout !== !done_last) begin
            errors++;
            $display("FAIL to_pulse d=%b got=%0d/%b exp=0/%b",
                     done_last, state, timeout, !done_last);
        end
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_clear d=%b got=%b exp=0", done_last, timeout);
        end
    endtask

    task automatic test_timeout();
        run_wait(1'b0);
        run_wait(1'b1);
    endtask

    task automatic test_priority();
        do_reset();
        ctl.jump_en_i   = 1'b1;
        ctl.jump_addr_i = 32'hABC0;
        ctl.ex_hold_i   = 1'b1;
        ctl.bus_stall_i = 1'b1;
        #1;
        checks++;
        if (mealy !== {6'b010011, 32'h0}) begin
            errors++;
            $display("FAIL prio_mealy got=%h exp=%h",
                     mealy, {6'b010011, 32'h0});
        end
        tick();
        clr_in();
        #1;
        checks++;
        if (state !== 2'd2 || mealy !== {6'b100011, 32'hABC0}) begin
            errors++;
            $display("FAIL prio_state got=%0d/%h exp=2/%h",
                     state, mealy, {6'b100011, 32'hABC0});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ctl.jump_en_i   = 1'b1;
        ctl.jump_addr_i = 32'h400;
        ctl.bus_stall_i = 1'b1;
        tick();
        clr_in();
        ctl.bus_stall_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || mealy !== 38'h0) begin
            errors++;
            $display("FAIL rmid_async got=%0d/%h exp=0/0", state, mealy);
        end
        rst_n = 1'b1;
        ctl.bus_stall_i = 1'b0;
        #1;
        checks++;
        if (mealy !== 38'h0 || fcnt !== 4'd0) begin
            errors++;
            $display("FAIL rmid_lost got=%h/%0d exp=0/0", mealy, fcnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            ctl.jump_en_i   = 1'b1;
            ctl.jump_addr_i = 32'(i * 4);
            tick();
        end
        clr_in();
        #1;
        checks++;
        if (fcnt !== 4'd1 || mealy !== 38'h0) begin
            errors++;
            $display("FAIL wrap got=%0d/%h exp=1/0", fcnt, mealy);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        clr_in();
        test_reset();
        test_jump();
        test_jump_stall();
        test_mdu();
        test_timeout();
        test_priority();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
